regencode: RTL and testbench
============================

# regencode

Register-address encoder: the issue-side counterpart of the register decode stage. It accepts a stream of full 4-bit register addresses and emits the compressed `set_pa` / `lower_reg_addr` fields that the decoder consumes. It tracks the decoder's play area (upper two address bits) and emits a play-area update only when the area changes or is unknown. It sits between address generation and the instruction/field output path, with valid/ready handshakes on both sides and full one-per-cycle throughput.

## Interface
- `REGENC_CNT_W`, default 16: width of the statistics counters (`REGENC_STATS_EN` only).
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  an input address is offered.
- `in_ready`  out  1  the block can accept an input this cycle.
- `in_reg_addr`  in  4  full register address: bits [3:2] are the play area, bits [1:0] are the lower address.
- `pa_invalidate`  in  1  single-cycle pulse: decoder play area is no longer known, e.g. after a jump target.
- `out_valid`  out  1  encoded fields are valid.
- `out_ready`  in  1  downstream accepts the fields.
- `out_set_pa`  out  3  bit 2 is the write enable, bits [1:0] are the play area.
- `out_lower_reg_addr`  out  2  lower register address.
- `prefix_count`  out  REGENC_CNT_W  number of emitted words with `out_set_pa[2]`=1 (statistics).
- `word_count`  out  REGENC_CNT_W  total number of emitted words (statistics).

## Operation
- Transfer rules:
  - An input is accepted when `in_valid && in_ready`.
  - An output is consumed when `out_valid && out_ready`.
- State registers:
  - `pa` (2 bits) and `pa_known` (1 bit), both cleared by reset.
  - All state is updated at input acceptance, in stream order.
- Encoding of an accepted address A:
  - If `!pa_known` or A[3:2] != `pa`, emit `set_pa={1,A[3:2]}`, then set `pa<=A[3:2]` and `pa_known<=1`.
  - Otherwise emit `set_pa={0,pa}`. Bits [1:0] are always driven to the current area and are never X.
  - In both cases `lower_reg_addr=A[1:0]`.
- `pa_invalidate` handling:
  - Asserting it clears `pa_known` at the next edge.
  - If it coincides with an acceptance, the accepted word is encoded with the pre-invalidate state, and `pa_known` still ends at 0.
  - The next accepted word therefore always carries a prefix, even when its area is unchanged.
- Buffering uses a 2-entry skid buffer with a main register and a skid register:
  - `in_ready = !skid_valid`, so it is registered-only and has no combinational path from `out_ready`.
  - When the main register is stalled and a word is accepted, the word goes to the skid register.
  - On drain, the skid entry moves to the main register.
- Ordering: output order equals input order, with no drops and no duplicates.
- Reset mid-stream: all buffered words are discarded and `pa_known`=0. The first post-reset word therefore carries a prefix.

## Timing
- Reset values:
  - `out_valid`=0, `out_set_pa`=3'b000, `out_lower_reg_addr`=2'b00.
  - `in_ready`=1.
  - `prefix_count`=0, `word_count`=0.
  - Inputs are ignored while `reset` is high.
- Latency: a word accepted at edge N is presented at `out_valid` after edge N (1 cycle) if the main register is empty, or is draining at N.
- Throughput: 1 word/cycle while `out_ready`=1.
- Output stability: while `out_valid && !out_ready`, the outputs hold stable.
- Capacity: at most 2 words are held. With both entries full, `in_ready`=0 until a consume occurs.
- Simultaneous events: accept and consume in the same cycle with the skid entry empty gives pass-through with occupancy unchanged.

## Configuration
- `REGENC_STATS_EN` defined:
  - `word_count` increments on every consumed output word.
  - `prefix_count` increments on every consumed word with `out_set_pa[2]`=1.
  - Both counters saturate at all-ones and clear on reset.
- `REGENC_STATS_EN` undefined:
  - The counter logic is removed.
  - `prefix_count` and `word_count` are tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then inputs 4'hD, 4'hE, 4'h3 with `out_ready`=1 -> outputs `{set_pa,lower}`: {3'b111,2'b01}, {3'b011,2'b10}, {3'b100,2'b11}, each one cycle after acceptance.
- Inputs 4'h5, 4'h6; pulse `pa_invalidate`; input 4'h7 -> outputs {3'b101,01}, {3'b001,10}, {3'b101,11}. The last word carries a prefix because of the invalidate.
- `pa_invalidate` in the same cycle as accepting 4'h6 (area already 1) -> that word is {3'b001,10}; the next 4'h4 is {3'b101,00}.
- Hold `out_ready`=0 and offer 4'h0, 4'h4, 4'h8 back-to-back -> `in_ready` drops after 2 accepts with outputs stable; release `out_ready` -> {3'b100,00}, {3'b101,00}, {3'b110,00} emitted in order, no loss.
- Random valid/ready stimulus, 10k words, against a reference model -> exact match. With `REGENC_STATS_EN`, `word_count`=10000 and `prefix_count` equal to the model's prefix tally.
- Assert `reset` with 2 words buffered -> next cycle `out_valid`=0 and `in_ready`=1; first new word 4'h1 -> {3'b100,01}.

Source files
------------

// File: rtl/regencode_if.sv
// Valid/ready bundle for the register-address encoder: address in, set_pa/lower fields out.
interface regencode_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_reg_addr;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_set_pa;
    logic [1:0] out_lower_reg_addr;

    modport master (
        output in_valid,
        output in_reg_addr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_set_pa,
        input  out_lower_reg_addr
    );

    modport slave (
        input  in_valid,
        input  in_reg_addr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_set_pa,
        output out_lower_reg_addr
    );
endinterface

// File: rtl/regencode.sv
// Register-address encoder with play-area tracking and a 2-entry skid buffer.
// Define REGENC_STATS_EN to build the saturating word/prefix statistics counters.
module regencode #(
    parameter int REGENC_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    regencode_if.slave              bus,
    input  logic                    pa_invalidate,
    output logic [REGENC_CNT_W-1:0] prefix_count,
    output logic [REGENC_CNT_W-1:0] word_count
);

    logic [1:0] r_pa;
    logic       r_pa_known;

    logic       r_main_valid;
    logic [2:0] r_main_set_pa;
    logic [1:0] r_main_lower;

    logic       r_skid_valid;
    logic [2:0] r_skid_set_pa;
    logic [1:0] r_skid_lower;

    logic       w_accept;
    logic       w_consume;
    logic       w_main_free;
    logic       w_prefix;
    logic [1:0] w_area;
    logic [1:0] w_lower;
    logic [2:0] w_enc_set_pa;

    assign w_area      = bus.in_reg_addr[3:2];
    assign w_lower     = bus.in_reg_addr[1:0];
    assign w_accept    = bus.in_valid && !r_skid_valid;
    assign w_consume   = r_main_valid && bus.out_ready;
    assign w_main_free = !r_main_valid || w_consume;

    // Encoding always uses the pre-invalidate state of the current cycle.
    assign w_prefix     = !r_pa_known || (w_area != r_pa);
    assign w_enc_set_pa = w_prefix ? {1'b1, w_area} : {1'b0, r_pa};

    assign bus.in_ready           = !r_skid_valid;
    assign bus.out_valid          = r_main_valid;
    assign bus.out_set_pa         = r_main_set_pa;
    assign bus.out_lower_reg_addr = r_main_lower;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pa       <= 2'b00;
            r_pa_known <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pa       <= w_area;
                r_pa_known <= 1'b1;
            end
            if (pa_invalidate) begin
                r_pa_known <= 1'b0;
            end
        end
    end

    // Skid entry only fills while main is stalled, and always drains first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid  <= 1'b0;
            r_main_set_pa <= 3'b000;
            r_main_lower  <= 2'b00;
            r_skid_valid  <= 1'b0;
            r_skid_set_pa <= 3'b000;
            r_skid_lower  <= 2'b00;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid  <= 1'b1;
                r_main_set_pa <= r_skid_set_pa;
                r_main_lower  <= r_skid_lower;
                r_skid_valid  <= 1'b0;
            end else if (w_accept) begin
                r_main_valid  <= 1'b1;
                r_main_set_pa <= w_enc_set_pa;
                r_main_lower  <= w_lower;
            end else begin
                r_main_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid  <= 1'b1;
            r_skid_set_pa <= w_enc_set_pa;
            r_skid_lower  <= w_lower;
        end
    end

`ifdef REGENC_STATS_EN
    logic [REGENC_CNT_W-1:0] r_word_count;
    logic [REGENC_CNT_W-1:0] r_prefix_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_count   <= '0;
            r_prefix_count <= '0;
        end else if (w_consume) begin
            if (r_word_count != {REGENC_CNT_W{1'b1}}) begin
                r_word_count <= r_word_count + 1'b1;
            end
            if (r_main_set_pa[2] &&
                (r_prefix_count != {REGENC_CNT_W{1'b1}})) begin
                r_prefix_count <= r_prefix_count + 1'b1;
            end
        end
    end

    assign word_count   = r_word_count;
    assign prefix_count = r_prefix_count;
`else
    assign word_count   = '0;
    assign prefix_count = '0;
`endif

endmodule

// File: tb/tb_regencode.sv
// Self-checking bench for regencode: directed table, stall/reset sequences, random stream vs model.
module tb_regencode;

    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          pa_invalidate;
    logic [CW-1:0] prefix_count;
    logic [CW-1:0] word_count;

    regencode_if u_if ();

    regencode #(.REGENC_CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (u_if.slave),
        .pa_invalidate(pa_invalidate),
        .prefix_count (prefix_count),
        .word_count   (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit         m_known;
    logic [1:0] m_pa;
    logic [4:0] q[$];
    logic [4:0] seen[$];
    int         m_words;
    int         m_pfx;
    int         n_acc;

    typedef struct {
        bit         vld;
        logic [3:0] addr;
        bit         inv;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] out_word();
        return {u_if.out_set_pa, u_if.out_lower_reg_addr};
    endfunction

    // One clock: update the model from the handshake, then check after the edge.
    task automatic cycle();
        bit         acc;
        bit         cons;
        bit         pfx;
        logic [3:0] a;
        logic [4:0] w;
        acc  = u_if.in_valid && u_if.in_ready;
        cons = u_if.out_valid && u_if.out_ready;
        a    = u_if.in_reg_addr;
        if (reset) begin
            q.delete();
            m_known = 1'b0;
            m_pa    = 2'b00;
            m_words = 0;
            m_pfx   = 0;
        end else begin
            if (cons) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    w = q.pop_front();
                    seen.push_back(w);
                    m_words++;
                    if (w[4]) m_pfx++;
                end
            end
            if (acc) begin
                n_acc++;
                pfx = !m_known || (a[3:2] != m_pa);
                if (pfx) w = {1'b1, a[3:2], a[1:0]};
                else     w = {1'b0, m_pa, a[1:0]};
                q.push_back(w);
                m_pa    = a[3:2];
                m_known = 1'b1;
            end
            if (pa_invalidate) m_known = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(u_if.out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(u_if.in_ready), 32'(q.size() < 2));
        if (q.size() != 0) chk("out_word", 32'(out_word()), 32'(q[0]));
    endtask

    task automatic idle_inputs();
        u_if.in_valid    = 1'b0;
        u_if.in_reg_addr = 4'h0;
        pa_invalidate    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [4:0] exp_stall[3];
        int         cyc;

        tbl[0] = '{1'b1, 4'hD, 1'b0, 5'b111_01};
        tbl[1] = '{1'b1, 4'hE, 1'b0, 5'b011_10};
        tbl[2] = '{1'b1, 4'h3, 1'b0, 5'b100_11};
        tbl[3] = '{1'b1, 4'h5, 1'b0, 5'b101_01};
        tbl[4] = '{1'b1, 4'h6, 1'b0, 5'b001_10};
        tbl[5] = '{1'b0, 4'h0, 1'b1, 5'b000_00};
        tbl[6] = '{1'b1, 4'h7, 1'b0, 5'b101_11};
        tbl[7] = '{1'b1, 4'h6, 1'b1, 5'b001_10};
        tbl[8] = '{1'b1, 4'h4, 1'b0, 5'b101_00};

        m_known = 1'b0;
        m_pa    = 2'b00;
        m_words = 0;
        m_pfx   = 0;
        n_acc   = 0;
        idle_inputs();
        u_if.out_ready = 1'b1;
        u_if.in_valid  = 1'b1;
        u_if.in_reg_addr = 4'hF;
        do_reset();
        idle_inputs();

        chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst_in_ready", 32'(u_if.in_ready), 32'd1);
        chk("rst_set_pa", 32'(u_if.out_set_pa), 32'd0);
        chk("rst_lower", 32'(u_if.out_lower_reg_addr), 32'd0);
        chk("rst_word_cnt", 32'(word_count), 32'd0);
        chk("rst_pfx_cnt", 32'(prefix_count), 32'd0);

        // Directed encoding table, one word per cycle, out_ready held high.
        for (int i = 0; i < 9; i++) begin
            u_if.in_valid    = tbl[i].vld;
            u_if.in_reg_addr = tbl[i].addr;
            pa_invalidate    = tbl[i].inv;
            cycle();
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_valid", i), 32'(u_if.out_valid), 32'd1);
                chk($sformatf("tbl%0d_word", i), 32'(out_word()),
                    32'(tbl[i].exp));
            end
        end
        idle_inputs();
        cycle();

        // Stall: third word must wait for space, nothing lost or reordered.
        seen.delete();
        u_if.out_ready = 1'b0;
        u_if.in_valid  = 1'b1;
        u_if.in_reg_addr = 4'h0;
        cycle();
        u_if.in_reg_addr = 4'h4;
        cycle();
        u_if.in_reg_addr = 4'h8;
        cycle();
        chk("stall_in_ready", 32'(u_if.in_ready), 32'd0);
        cycle();
        cycle();
        chk("stall_hold", 32'(out_word()), 32'b10000);
        u_if.out_ready = 1'b1;
        cyc = 0;
        while (n_acc == 0 || u_if.in_ready == 1'b0) begin
            cycle();
            cyc++;
            if (cyc > 8) break;
            if (seen.size() > 0) break;
        end
        cycle();
        u_if.in_valid = 1'b0;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            cycle();
            cyc++;
        end
        exp_stall[0] = 5'b100_00;
        exp_stall[1] = 5'b101_00;
        exp_stall[2] = 5'b110_00;
        chk("stall_count", 32'(seen.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < seen.size())
                chk($sformatf("stall_word%0d", i), 32'(seen[i]),
                    32'(exp_stall[i]));
        end

        // Reset with two words buffered.
        u_if.out_ready   = 1'b0;
        u_if.in_valid    = 1'b1;
        u_if.in_reg_addr = 4'h9;
        cycle();
        u_if.in_reg_addr = 4'hA;
        cycle();
        u_if.in_valid = 1'b0;
        chk("full_in_ready", 32'(u_if.in_ready), 32'd0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(u_if.out_valid), 32'd0);
        chk("mid_rst_ready", 32'(u_if.in_ready), 32'd1);
        u_if.out_ready   = 1'b1;
        u_if.in_valid    = 1'b1;
        u_if.in_reg_addr = 4'h1;
        cycle();
        u_if.in_valid = 1'b0;
        chk("post_rst_word", 32'(out_word()), 32'b100_01);
        cycle();

        // Random stream of 10k words against the model.
        do_reset();
        n_acc = 0;
        cyc   = 0;
        while ((n_acc < 10000 || q.size() != 0) && cyc < 80000) begin
            u_if.in_valid    = (n_acc < 10000) && ($urandom_range(0, 3) != 0);
            u_if.in_reg_addr = 4'($urandom_range(0, 15));
            pa_invalidate    = ($urandom_range(0, 7) == 0);
            u_if.out_ready   = ($urandom_range(0, 3) != 0);
            cycle();
            cyc++;
        end
        idle_inputs();
        u_if.out_ready = 1'b1;
        chk("rand_budget", 32'(cyc < 80000), 32'd1);
        chk("rand_words", 32'(m_words), 32'd10000);
        chk("rand_drained", 32'(q.size()), 32'd0);
`ifdef REGENC_STATS_EN
        chk("stat_words", 32'(word_count), 32'd10000);
        chk("stat_prefix", 32'(prefix_count), 32'(m_pfx));
`else
        chk("stat_words_off", 32'(word_count), 32'd0);
        chk("stat_prefix_off", 32'(prefix_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
